// File: rtl/keypad_pkg.sv
// Shared key-code constants, FSM state encodings and slot decode for the dose-entry keypad.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE = 5'h00;
    localparam logic [4:0] KEY_0    = 5'h10;
    localparam logic [4:0] KEY_1    = 5'h11;
    localparam logic [4:0] KEY_2    = 5'h12;
    localparam logic [4:0] KEY_3    = 5'h13;
    localparam logic [4:0] KEY_4    = 5'h14;
    localparam logic [4:0] KEY_5    = 5'h15;
    localparam logic [4:0] KEY_6    = 5'h16;
    localparam logic [4:0] KEY_7    = 5'h17;
    localparam logic [4:0] KEY_8    = 5'h18;
    localparam logic [4:0] KEY_9    = 5'h19;
    localparam logic [4:0] KEY_A    = 5'h1A;
    localparam logic [4:0] KEY_B    = 5'h1B;
    localparam logic [4:0] KEY_C    = 5'h1C;
    localparam logic [4:0] KEY_D    = 5'h1D;
    localparam logic [4:0] KEY_HASH = 5'h1E;
    localparam logic [4:0] KEY_STAR = 5'h1F;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EDIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Slot number of an A..D key code (A=0 .. D=3).
    function automatic logic [1:0] slot_of(input logic [4:0] code);
        logic [4:0] diff;
        diff = code - KEY_A;
        return diff[1:0];
    endfunction

endpackage

// File: rtl/keypad_entry_bcd_to_bin.sv
// Combinational NDIG-digit BCD to binary converter (Horner chain, most significant digit first).
module bcd_to_bin #(
    parameter int NDIG  = 4,
    parameter int BIN_W = 14
) (
    input  logic [4*NDIG-1:0] bcd,
    output logic [BIN_W-1:0]  bin
);

    logic [BIN_W-1:0] acc [NDIG+1];

    assign acc[NDIG] = '0;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_horner
            assign acc[gi] = acc[gi+1] * BIN_W'(10) + BIN_W'(bcd[4*gi +: 4]);
        end
    endgenerate

    assign bin = acc[0];

endmodule

// File: rtl/keypad_entry.sv
// Keypad dose-entry assembler: slot select, BCD digit entry with delete/commit, idle timeout and
// valid/ack hand-off. Define KEYPAD_ENTRY_BINARY_EN to also register the binary value on commit.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int TIMEOUT = 50000,
    parameter int BIN_W   = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [4:0]                  numeros,
    input  logic                        ack,
    output logic [4*NDIG-1:0]           valor,
    output logic [$clog2(NDIG+1)-1:0]   cuenta,
    output logic [1:0]                  slot,
    output logic                        valido,
    output logic                        error,
    output logic [BIN_W-1:0]            valor_bin,
    output logic [1:0]                  estado
);

    localparam int CW = $clog2(NDIG + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]          state_reg,  state_next;
    logic [4*NDIG-1:0]   valor_reg,  valor_next;
    logic [CW-1:0]       cuenta_reg, cuenta_next;
    logic [1:0]          slot_reg,   slot_next;
    logic                valido_reg, valido_next;
    logic                error_reg,  error_next;
    logic [TW-1:0]       tmr_reg,    tmr_next;

    logic key_valid, is_digit, is_slot, is_hash, is_star;

    // All 16 low-nibble codes are mapped, so bit4 alone qualifies a key.
    assign key_valid = numeros[4];
    assign is_digit  = (numeros >= KEY_0) && (numeros <= KEY_9);
    assign is_slot   = (numeros >= KEY_A) && (numeros <= KEY_D);
    assign is_hash   = (numeros == KEY_HASH);
    assign is_star   = (numeros == KEY_STAR);

    always_comb begin
        state_next  = state_reg;
        valor_next  = valor_reg;
        cuenta_next = cuenta_reg;
        slot_next   = slot_reg;
        valido_next = valido_reg;
        error_next  = 1'b0;
        tmr_next    = '0;

        case (state_reg)
            IDLE: begin
                if (is_slot) begin
                    slot_next   = slot_of(numeros);
                    valor_next  = '0;
                    cuenta_next = '0;
                    state_next  = EDIT;
                end
            end

            EDIT: begin
                if (key_valid) begin
                    if (is_digit) begin
                        if (cuenta_reg < CW'(NDIG)) begin
                            valor_next  = {valor_reg[4*NDIG-5:0], numeros[3:0]};
                            cuenta_next = cuenta_reg + CW'(1);
                        end else begin
                            error_next = 1'b1;
                        end
                    end else if (is_star) begin
                        if (cuenta_reg != '0) begin
                            valor_next  = valor_reg >> 4;
                            cuenta_next = cuenta_reg - CW'(1);
                        end else begin
                            state_next = IDLE;
                            slot_next  = '0;
                        end
                    end else if (is_hash) begin
                        if (cuenta_reg != '0) begin
                            state_next  = HOLD;
                            valido_next = 1'b1;
                        end else begin
                            error_next = 1'b1;
                        end
                    end else if (is_slot) begin
                        slot_next   = slot_of(numeros);
                        valor_next  = '0;
                        cuenta_next = '0;
                    end
                end else if (tmr_reg == TW'(TIMEOUT - 1)) begin
                    state_next  = IDLE;
                    valor_next  = '0;
                    cuenta_next = '0;
                    slot_next   = '0;
                    error_next  = 1'b1;
                end else begin
                    tmr_next = tmr_reg + TW'(1);
                end
            end

            HOLD: begin
                // Keys are dropped here, including one arriving with ack.
                if (ack) begin
                    state_next  = IDLE;
                    valido_next = 1'b0;
                    valor_next  = '0;
                    cuenta_next = '0;
                    slot_next   = '0;
                end
            end

            default: begin
                state_next  = IDLE;
                valido_next = 1'b0;
                valor_next  = '0;
                cuenta_next = '0;
                slot_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            valor_reg  <= '0;
            cuenta_reg <= '0;
            slot_reg   <= '0;
            valido_reg <= 1'b0;
            error_reg  <= 1'b0;
            tmr_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            valor_reg  <= valor_next;
            cuenta_reg <= cuenta_next;
            slot_reg   <= slot_next;
            valido_reg <= valido_next;
            error_reg  <= error_next;
            tmr_reg    <= tmr_next;
        end
    end

`ifdef KEYPAD_ENTRY_BINARY_EN
    logic [BIN_W-1:0] bin_conv;
    logic [BIN_W-1:0] bin_reg;
    logic             commit, release_hold;

    assign commit       = (state_reg == EDIT) && (state_next == HOLD);
    assign release_hold = (state_reg == HOLD) && (state_next == IDLE);

    bcd_to_bin #(
        .NDIG  (NDIG),
        .BIN_W (BIN_W)
    ) u_bcd_to_bin (
        .bcd (valor_reg),
        .bin (bin_conv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bin_reg <= '0;
        else if (commit)
            bin_reg <= bin_conv;
        else if (release_hold)
            bin_reg <= '0;
    end

    assign valor_bin = bin_reg;
`else
    assign valor_bin = '0;
`endif

    assign valor  = valor_reg;
    assign cuenta = cuenta_reg;
    assign slot   = slot_reg;
    assign valido = valido_reg;
    assign error  = error_reg;
    assign estado = state_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry (short TIMEOUT so the idle expiry is reachable).
module tb_keypad_entry;

    localparam int NDIG    = 4;
    localparam int TIMEOUT = 20;
    localparam int BIN_W   = 14;

`ifdef KEYPAD_ENTRY_BINARY_EN
    localparam int BIN_EN = 1;
`else
    localparam int BIN_EN = 0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [4:0]                numeros = 5'h00;
    logic                      ack = 1'b0;
    logic [4*NDIG-1:0]         valor;
    logic [$clog2(NDIG+1)-1:0] cuenta;
    logic [1:0]                slot;
    logic                      valido;
    logic                      error;
    logic [BIN_W-1:0]          valor_bin;
    logic [1:0]                estado;

    int checks = 0;
    int errors = 0;
    int err_pulses;

    keypad_entry #(
        .NDIG    (NDIG),
        .TIMEOUT (TIMEOUT),
        .BIN_W   (BIN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .numeros   (numeros),
        .ack       (ack),
        .valor     (valor),
        .cuenta    (cuenta),
        .slot      (slot),
        .valido    (valido),
        .error     (error),
        .valor_bin (valor_bin),
        .estado    (estado)
    );

    always #5 clk = ~clk;

    // Present one code (and ack) for exactly one rising edge, then sample 1 ns later.
    task automatic cycle(input logic [4:0] code, input logic a);
        numeros = code;
        ack     = a;
        @(posedge clk);
        #1;
        numeros = 5'h00;
        ack     = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [15:0] v,
                           input logic [2:0] c, input logic [1:0] s, input logic vd,
                           input logic e);
        chk({tag, ".estado"}, 32'(estado), 32'(st));
        chk({tag, ".valor"},  32'(valor),  32'(v));
        chk({tag, ".cuenta"}, 32'(cuenta), 32'(c));
        chk({tag, ".slot"},   32'(slot),   32'(s));
        chk({tag, ".valido"}, 32'(valido), 32'(vd));
        chk({tag, ".error"},  32'(error),  32'(e));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 2'd0, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);
        chk("reset.valor_bin", 32'(valor_bin), 32'd0);
        rst_n = 1'b1;

        // B 1 2 5 # -> commit slot 1, 0125
        cycle(5'h1B, 1'b0);
        chk_all("selB", 2'd1, 16'h0000, 3'd0, 2'd1, 1'b0, 1'b0);
        cycle(5'h11, 1'b0);
        cycle(5'h12, 1'b0);
        cycle(5'h15, 1'b0);
        chk_all("dig125", 2'd1, 16'h0125, 3'd3, 2'd1, 1'b0, 1'b0);
        cycle(5'h1E, 1'b0);
        chk_all("commit", 2'd2, 16'h0125, 3'd3, 2'd1, 1'b1, 1'b0);
        chk("commit.valor_bin", 32'(valor_bin), (BIN_EN != 0) ? 32'd125 : 32'd0);

        // Keys in HOLD are ignored silently
        cycle(5'h13, 1'b0);
        chk_all("hold3", 2'd2, 16'h0125, 3'd3, 2'd1, 1'b1, 1'b0);
        cycle(5'h1A, 1'b0);
        chk_all("holdA", 2'd2, 16'h0125, 3'd3, 2'd1, 1'b1, 1'b0);
        chk("holdA.valor_bin", 32'(valor_bin), (BIN_EN != 0) ? 32'd125 : 32'd0);
        cycle(5'h00, 1'b1);
        chk_all("ack", 2'd0, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);
        chk("ack.valor_bin", 32'(valor_bin), 32'd0);

        // Overflow on fifth digit, then delete
        cycle(5'h1D, 1'b0);
        cycle(5'h11, 1'b0);
        cycle(5'h12, 1'b0);
        cycle(5'h13, 1'b0);
        cycle(5'h14, 1'b0);
        chk_all("full", 2'd1, 16'h1234, 3'd4, 2'd3, 1'b0, 1'b0);
        cycle(5'h15, 1'b0);
        chk_all("ovf", 2'd1, 16'h1234, 3'd4, 2'd3, 1'b0, 1'b1);
        cycle(5'h00, 1'b0);
        chk("ovf.pulse_end", 32'(error), 32'd0);
        cycle(5'h1F, 1'b0);
        chk_all("del", 2'd1, 16'h0123, 3'd3, 2'd3, 1'b0, 1'b0);

        // Empty commit rejected, reselect, cancel to IDLE
        cycle(5'h1A, 1'b0);
        chk_all("selA", 2'd1, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);
        cycle(5'h1E, 1'b0);
        chk_all("hash_empty", 2'd1, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b1);
        cycle(5'h1C, 1'b0);
        chk_all("selC", 2'd1, 16'h0000, 3'd0, 2'd2, 1'b0, 1'b0);
        cycle(5'h1F, 1'b0);
        chk_all("cancel", 2'd0, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);

        // Idle timeout: exactly TIMEOUT quiet edges after the last key
        cycle(5'h1C, 1'b0);
        cycle(5'h17, 1'b0);
        chk_all("to_entry", 2'd1, 16'h0007, 3'd1, 2'd2, 1'b0, 1'b0);
        err_pulses = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            cycle(5'h00, 1'b0);
            if (error) err_pulses++;
        end
        chk("to_before.estado", 32'(estado), 32'd1);
        cycle(5'h00, 1'b0);
        if (error) err_pulses++;
        chk_all("to_expire", 2'd0, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(5'h00, 1'b0);
            if (error) err_pulses++;
        end
        chk("to_single_pulse", 32'(err_pulses), 32'd1);

        // Key on the last quiet cycle wins and restarts the count
        cycle(5'h1C, 1'b0);
        cycle(5'h17, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(5'h00, 1'b0);
        cycle(5'h18, 1'b0);
        chk_all("to_key_wins", 2'd1, 16'h0078, 3'd2, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(5'h00, 1'b0);
        chk("to_restart.estado", 32'(estado), 32'd1);
        cycle(5'h00, 1'b0);
        chk_all("to_restart_expire", 2'd0, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b1);

        // Key coincident with ack is dropped
        cycle(5'h1B, 1'b0);
        cycle(5'h00, 1'b1);
        chk("ack_in_edit.estado", 32'(estado), 32'd1);
        cycle(5'h19, 1'b0);
        cycle(5'h1E, 1'b0);
        chk_all("commit9", 2'd2, 16'h0009, 3'd1, 2'd1, 1'b1, 1'b0);
        chk("commit9.valor_bin", 32'(valor_bin), (BIN_EN != 0) ? 32'd9 : 32'd0);
        cycle(5'h1A, 1'b1);
        chk_all("ack_key", 2'd0, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);
        cycle(5'h00, 1'b0);
        chk("ack_key.after", 32'(estado), 32'd0);

        // Asynchronous reset mid-entry
        cycle(5'h1B, 1'b0);
        cycle(5'h13, 1'b0);
        chk_all("pre_rst", 2'd1, 16'h0003, 3'd1, 2'd1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'd0, 16'h0000, 3'd0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("async_rst.hold", 32'(estado), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Consumes the 5-bit key-code stream produced by the matrix-keypad comparator: bit4 = valid, bits3:0 = key, one single-cycle code per press.
- Assembles a dose entry for the pill dispenser:
  - A–D selects a medicine slot (0–3).
  - Digits accumulate as NDIG BCD digits.
  - '*' deletes the last digit or cancels the entry.
  - '#' commits the entry.
- The committed slot/value is presented with a valid/ack handshake to the dosing controller.

Parameters:
- NDIG, 4, maximum number of BCD digits per entry.
- TIMEOUT, 50000, idle clock cycles in EDIT before the entry is abandoned.
- BIN_W, 14, width of the binary value output; must hold 10^NDIG-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- numeros  in  5  key code: bit4 = pulse valid; 0x10–0x19 = digits 0–9; 0x1A–0x1D = A–D; 0x1E = '#'; 0x1F = '*'; 0x00 = no key.
- ack  in  1  consumer accepts the committed entry.
- valor  out  4*NDIG  BCD digits; digit 0 is in the LSBs and is the most recent entry.
- cuenta  out  clog2(NDIG+1)  number of digits entered.
- slot  out  2  selected slot (A=0 … D=3).
- valido  out  1  committed entry pending.
- error  out  1  one-cycle pulse on a rejected key or on timeout.
- valor_bin  out  BIN_W  binary equivalent of valor (see Optional Feature).
- estado  out  2  current state: IDLE=0, EDIT=1, HOLD=2.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - valor, cuenta, slot, valido, error, valor_bin and timeout counter all 0.
- Single clock domain. A key is processed when numeros[4]=1. Outputs update on the next clk edge (1-cycle latency). error is 0 on every cycle that has no error event.
- IDLE:
  - A–D: slot←code−0x1A, valor←0, cuenta←0, go to EDIT.
  - Digits, '*', '#': ignored, no error.
- EDIT, per key:
  - Digit with cuenta<NDIG: valor←{valor shifted left 4 bits, digit}, cuenta+1.
  - Digit with cuenta==NDIG: ignored, error pulse.
  - '*' with cuenta>0: valor shifted right 4 bits (MSBs zero-filled), cuenta−1.
  - '*' with cuenta==0: go to IDLE, slot←0.
  - '#' with cuenta>0: go to HOLD, valido←1.
  - '#' with cuenta==0: error pulse, stay in EDIT.
  - A–D: reselect slot, clear valor/cuenta, stay in EDIT.
- EDIT timeout:
  - Any valid key resets the timeout counter.
  - When the counter reaches TIMEOUT−1 with no key, the next edge goes to IDLE, clears valor/cuenta/slot and pulses error.
  - A key arriving on that same cycle takes priority: the key is processed and the counter resets.
- HOLD:
  - valido=1; valor/slot/cuenta are held stable.
  - All keys are ignored, no error.
  - ack=1 → next edge: valido←0, clear valor/cuenta/slot, go to IDLE.
  - ack is ignored outside HOLD.
  - A key coincident with ack is dropped.
- Invalid codes (bit4=1 with bits3:0 outside the map) cannot occur; they are treated as no key.
- The timeout counter only runs in EDIT and is held at 0 elsewhere.
- Reset asserted mid-entry or in HOLD aborts immediately; no valido pulse is produced.

Optional Feature:
- Macro: KEYPAD_ENTRY_BINARY_EN.
- Defined: valor_bin = sum of digit_i·10^i, registered in the same edge that sets valido; held during HOLD; cleared on ack.
- Undefined: valor_bin tied to 0 and no conversion logic is built.

Decomposition:
- Package keypad_pkg holds:
  - Key-code constants: KEY_NONE=5'h00, KEY_0..KEY_9=5'h10..5'h19, KEY_A..KEY_D=5'h1A..5'h1D, KEY_HASH=5'h1E, KEY_STAR=5'h1F.
  - State encodings IDLE/EDIT/HOLD.
- One sub-module: bcd_to_bin, a combinational NDIG-digit BCD-to-binary converter, instantiated only under KEYPAD_ENTRY_BINARY_EN.

Test Plan:
- Reset, then 0x1B, 0x11, 0x12, 0x15, 0x1E → slot=1, valor=0x0125, cuenta=3, valido=1, valor_bin=125 (feature on); pulse ack → IDLE, all cleared next cycle.
- In EDIT enter 0x11, 0x12, 0x13, 0x14, 0x15 → valor=0x1234, error pulses on the fifth key; 0x1F → valor=0x0123, cuenta=3.
- 0x1A then 0x1E with no digits → error pulse, stays EDIT; 0x1F → IDLE, slot=0.
- 0x1C, 0x17, then no keys for TIMEOUT cycles → IDLE, valor=0, single error pulse; repeat with a key at cycle TIMEOUT−1 → stays EDIT.
- In HOLD apply 0x13 and 0x1A → valor/slot unchanged, no error; key on the same cycle as ack → dropped, IDLE.
- Assert rst_n=0 mid-EDIT between clock edges → all outputs 0 immediately, estado=IDLE.
